// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and default constants for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_DVSR    = 326;
  localparam int DEF_DVSR_W  = 9;
  localparam int OS_TICKS    = 16;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Oversample tick generator: s_tick is high for one clk every DVSR clks.
// clr restarts the count so the first tick lands DVSR clks after frame start.
module baud_tick_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int DVSR   = DEF_DVSR,
  parameter int DVSR_W = DEF_DVSR_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic s_tick
);

  logic [DVSR_W-1:0] cnt;

  assign s_tick = (cnt == DVSR_W'(DVSR - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || s_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter popping words straight from a FIFO head; tx lags the FSM by one clk.
// A new frame starts only from IDLE with data present and tx_en high; frames are never aborted.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int DVSR    = DEF_DVSR,
  parameter int DVSR_W  = DEF_DVSR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  input  logic            tx_en,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int S_W = (SB_TICK > OS_TICKS) ? $clog2(SB_TICK) : $clog2(OS_TICKS);
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  tx_state_e       state, state_n;
  logic [S_W-1:0]  s_cnt, s_cnt_n;
  logic [N_W-1:0]  n_cnt, n_cnt_n;
  logic [DBIT-1:0] shreg, shreg_n;
  logic            tx_reg, tx_n;
  logic            s_tick, clr;

  baud_tick_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .s_tick (s_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      shreg  <= '0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_n;
      s_cnt  <= s_cnt_n;
      n_cnt  <= n_cnt_n;
      shreg  <= shreg_n;
      tx_reg <= tx_n;
    end
  end

  always_comb begin
    state_n      = state;
    s_cnt_n      = s_cnt;
    n_cnt_n      = n_cnt;
    shreg_n      = shreg;
    tx_n         = tx_reg;
    fifo_rd      = 1'b0;
    clr          = 1'b0;
    tx_done_tick = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty && tx_en) begin
          fifo_rd = 1'b1;
          clr     = 1'b1;
          shreg_n = fifo_r_data;
          s_cnt_n = '0;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (s_tick) begin
          if (s_cnt == S_W'(OS_TICKS - 1)) begin
            s_cnt_n = '0;
            n_cnt_n = '0;
            state_n = DATA;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (s_tick) begin
          if (s_cnt == S_W'(OS_TICKS - 1)) begin
            s_cnt_n = '0;
            shreg_n = shreg >> 1;
            if (n_cnt == N_W'(DBIT - 1)) begin
              state_n = STOP;
            end else begin
              n_cnt_n = n_cnt + 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (s_tick) begin
          if (s_cnt == S_W'(SB_TICK - 1)) begin
            tx_done_tick = 1'b1;
            state_n      = IDLE;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench: FIFO model feeding two transmitters (DVSR=4 directed, DVSR=1 random), serial decoder scoreboard.
module tb_fifo_uart_tx;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sel   = 1'b0;
  logic tx_en = 1'b0;
  logic f_wr  = 1'b0;
  logic [7:0] f_wdat = 8'h00;
  logic mon_en = 1'b1;

  logic [7:0] fmem [0:255];
  int f_wp, f_rp, f_cnt;
  logic [7:0] r_data;

  logic rd_d, tx_d, busy_d, done_d;
  logic rd_r, tx_r, busy_r, done_r;
  logic rd_act, tx_act, busy_act, done_act, f_empty;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_count = 0;
  int last_rd = 0;
  int n_frames = 0;
  logic prev_rd = 1'b0;
  logic [7:0] exp_q[$];
  int fall_q[$];

  always #5 clk = ~clk;

  assign f_empty  = (f_cnt == 0);
  assign r_data   = fmem[f_rp[7:0]];
  assign rd_act   = sel ? rd_r : rd_d;
  assign tx_act   = sel ? tx_r : tx_d;
  assign busy_act = sel ? busy_r : busy_d;
  assign done_act = sel ? done_r : done_d;

  fifo_uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(3)) dut_d (
    .clk(clk), .reset(reset), .fifo_empty(sel | f_empty), .fifo_r_data(r_data),
    .fifo_rd(rd_d), .tx_en(~sel & tx_en), .tx(tx_d), .tx_busy(busy_d), .tx_done_tick(done_d)
  );

  fifo_uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(1), .DVSR_W(1)) dut_r (
    .clk(clk), .reset(reset), .fifo_empty(~sel | f_empty), .fifo_r_data(r_data),
    .fifo_rd(rd_r), .tx_en(sel & tx_en), .tx(tx_r), .tx_busy(busy_r), .tx_done_tick(done_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: write visible one clk later, pop on rd when non-empty
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      f_wp  <= 0;
      f_rp  <= 0;
      f_cnt <= 0;
    end else begin
      if (f_wr) begin
        fmem[f_wp[7:0]] <= f_wdat;
        f_wp <= f_wp + 1;
      end
      if (rd_act && f_cnt > 0) f_rp <= f_rp + 1;
      f_cnt <= f_cnt + (f_wr ? 1 : 0) - ((rd_act && f_cnt > 0) ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    if (!reset && rd_act) begin
      chk("rd_nonempty", {31'd0, f_empty}, 32'd0);
      chk("rd_consec", {31'd0, prev_rd}, 32'd0);
      rd_count++;
      last_rd = cyc;
    end
    prev_rd = rd_act;
  end

  // Serial decoder: walks one whole frame cycle by cycle from the falling start edge
  initial begin
    int L, t0, done_at;
    logic bad;
    logic lvl [0:9];
    logic [7:0] dat;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx_act == 1'b0) begin
        L = sel ? 16 : 64;
        t0 = cyc;
        fall_q.push_back(t0);
        chk("start_lat", t0 - last_rd, 2);
        bad = 1'b0;
        done_at = -1;
        for (int i = 0; i < 10 * L; i++) begin
          if (i > 0) @(negedge clk);
          if (i % L == 0) lvl[i / L] = tx_act;
          else if (tx_act !== lvl[i / L]) bad = 1'b1;
          if (i < 10 * L - 1 && busy_act !== 1'b1) bad = 1'b1;
          if (done_act === 1'b1) begin
            if (done_at < 0) done_at = i;
            else bad = 1'b1;
          end
        end
        for (int b = 0; b < 8; b++) dat[b] = lvl[b + 1];
        chk("levels", {31'd0, bad}, 32'd0);
        chk("stop_bit", {31'd0, lvl[9]}, 32'd1);
        chk("done_pos", done_at, 10 * L - 2);
        chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk("data", {24'd0, dat}, {24'd0, exp_q.pop_front()});
        n_frames++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    f_wr = 1'b1;
    f_wdat = d;
    exp_q.push_back(d);
    step();
    f_wr = 1'b0;
  endtask

  task automatic quiet(input int n, input string tag);
    logic bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (tx_act !== 1'b1 || rd_act !== 1'b0 || busy_act !== 1'b0) bad = 1'b1;
      step();
    end
    chk(tag, {31'd0, bad}, 32'd0);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || busy_act || f_cnt != 0) && c < budget) begin
      step();
      c++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int rd0, nfr0, pushed;
    repeat (3) step();
    @(negedge clk);
    chk("rst_tx", {31'd0, tx_d}, 32'd1);
    chk("rst_busy", {31'd0, busy_d}, 32'd0);
    chk("rst_rd", {31'd0, rd_d}, 32'd0);
    chk("rst_done", {31'd0, done_d}, 32'd0);
    step();
    reset = 1'b0;
    quiet(1000, "idle_quiet");

    // single byte
    tx_en = 1'b1;
    rd0 = rd_count;
    push(8'hA5);
    drain(2000);
    chk("a5_rd", rd_count - rd0, 1);
    chk("a5_empty", f_cnt, 0);

    // preload three with tx_en low, then release
    tx_en = 1'b0;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    quiet(50, "en_block");
    rd0 = rd_count;
    fall_q.delete();
    tx_en = 1'b1;
    @(negedge clk);
    chk("start_on_en", {31'd0, rd_act}, 32'd1);
    step();
    drain(3000);
    chk("b2b_rd", rd_count - rd0, 3);
    chk("b2b_frames", fall_q.size(), 3);
    if (fall_q.size() >= 3) begin
      chk("period01", fall_q[1] - fall_q[0], 641);
      chk("period12", fall_q[2] - fall_q[1], 641);
    end

    // tx_en dropped mid-frame
    rd0 = rd_count;
    push(8'h3C);
    push(8'hC3);
    repeat (200) step();
    tx_en = 1'b0;
    repeat (800) step();
    chk("drop_rd", rd_count - rd0, 1);
    chk("drop_busy", {31'd0, busy_act}, 32'd0);
    chk("drop_left", f_cnt, 1);
    tx_en = 1'b1;
    drain(2000);

    // reset mid-frame
    mon_en = 1'b0;
    push(8'h96);
    repeat (300) step();
    chk("mid_busy", {31'd0, busy_act}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_tx", {31'd0, tx_act}, 32'd1);
    chk("arst_busy", {31'd0, busy_act}, 32'd0);
    exp_q.delete();
    repeat (3) step();
    reset = 1'b0;
    rd0 = rd_count;
    quiet(100, "post_rst_quiet");
    chk("post_rst_rd", rd_count - rd0, 0);
    mon_en = 1'b1;
    push(8'h5A);
    drain(2000);

    // random traffic on the fast instance
    sel = 1'b1;
    repeat (5) step();
    rd0 = rd_count;
    nfr0 = n_frames;
    pushed = 0;
    for (int c = 0; c < 60000 && (pushed < 200 || exp_q.size() != 0 || busy_act); c++) begin
      tx_en = (pushed >= 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (pushed < 200 && $urandom_range(0, 119) == 0) begin
        f_wr = 1'b1;
        f_wdat = 8'($urandom_range(0, 255));
        exp_q.push_back(f_wdat);
        pushed++;
      end else begin
        f_wr = 1'b0;
      end
      step();
    end
    f_wr = 1'b0;
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_rd", rd_count - rd0, 200);
    chk("rand_frames", n_frames - nfr0, 200);
    chk("rand_empty", f_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
